// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector datapath: ALU op codes, reduction
// op/state enums, and the width-generic identity/combine functions used by
// the reduction unit.
package vector_pkg;

  // Widest element the width-generic helpers support.
  localparam int RED_MAX_BITS = 64;

  typedef logic [RED_MAX_BITS-1:0] red_word_t;

  // Element ALU operation encoding.
  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;
  localparam logic [2:0] ALU_OP_MAX = 3'd5;
  localparam logic [2:0] ALU_OP_MIN = 3'd6;

  typedef enum logic [1:0] {
    RED_SUM = 2'b00,
    RED_MAX = 2'b01,
    RED_MIN = 2'b10,
    RED_XOR = 2'b11
  } reduce_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } reduce_state_t;

  // Neutral starting value of the accumulator for a fold of width 'bits'.
  function automatic red_word_t reduce_identity(input reduce_op_t op, input int bits);
    red_word_t id;
    case (op)
      RED_SUM: id = '0;
      RED_MAX: id = red_word_t'(1) << (bits - 1);
      RED_MIN: id = (red_word_t'(1) << (bits - 1)) - red_word_t'(1);
      RED_XOR: id = '0;
      default: id = '0;
    endcase
    return id;
  endfunction

  // Combine two zero-extended 'bits'-wide operands. Signed compares shift the
  // element sign bit up to bit 63 so the native signed compare applies.
  // The sum may carry above 'bits'; callers truncate to the element width.
  function automatic red_word_t reduce_combine2(input reduce_op_t op, input red_word_t a,
                                                input red_word_t b, input int bits);
    red_word_t r;
    logic signed [RED_MAX_BITS-1:0] sa;
    logic signed [RED_MAX_BITS-1:0] sb;
    sa = $signed(a << (RED_MAX_BITS - bits));
    sb = $signed(b << (RED_MAX_BITS - bits));
    case (op)
      RED_SUM: r = a + b;
      RED_MAX: r = (sa > sb) ? a : b;
      RED_MIN: r = (sa < sb) ? a : b;
      RED_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_lane_tree.sv
// Combinational fold of LANES elements plus the running accumulator.
// Elements are padded to a power of two with the op identity and folded
// pairwise in a log2-depth tree; the tree root is then merged with acc.
module reduce_lane_tree
  import vector_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int LANES = 4
) (
  input  reduce_op_t       op,
  input  logic [BITS-1:0]  acc,
  input  logic [BITS-1:0]  elems [LANES],
  output logic [BITS-1:0]  combined
);

  localparam int LOG = $clog2(LANES);
  localparam int P   = 1 << LOG;

  for (genvar l = 0; l <= LOG; l++) begin : g_lvl
    localparam int W = P >> l;
    logic [BITS-1:0] val_s [W];
    for (genvar j = 0; j < W; j++) begin : g_n
      if (l == 0) begin : g_leaf
        if (j < LANES) begin : g_real
          assign val_s[j] = elems[j];
        end else begin : g_pad
          assign val_s[j] = BITS'(reduce_identity(op, BITS));
        end
      end else begin : g_cmb
        assign val_s[j] = BITS'(reduce_combine2(op,
                                                RED_MAX_BITS'(g_lvl[l-1].val_s[2*j]),
                                                RED_MAX_BITS'(g_lvl[l-1].val_s[2*j+1]),
                                                BITS));
      end
    end
  end

  assign combined = BITS'(reduce_combine2(op, RED_MAX_BITS'(acc),
                                          RED_MAX_BITS'(g_lvl[LOG].val_s[0]), BITS));

endmodule

// File: rtl/vector_reduce_unit_checker.sv
// Elaboration-time parameter legality checks for vector_reduce_unit.
module vector_reduce_unit_checker
  import vector_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int LANES = 4
) ();

  if (LANES < 1 || LANES > N) begin : g_lanes_range
    $error("vector_reduce_unit: LANES must be in 1..N");
  end else if ((N % LANES) != 0) begin : g_lanes_div
    $error("vector_reduce_unit: N must be a multiple of LANES");
  end

  if (BITS < 1 || BITS > RED_MAX_BITS) begin : g_bits_range
    $error("vector_reduce_unit: BITS out of supported range");
  end

endmodule

// File: rtl/vector_reduce_unit.sv
// Sequential vector reduction: snapshots an N-element vector on start and
// folds LANES elements per cycle into a single scalar (sum/max/min/xor),
// reporting it with a one-cycle done pulse.
module vector_reduce_unit
  import vector_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] V [N],
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  // Index of the final lane group; the step may wrap when LANES == N, which
  // is harmless because the last group always exits ACCUM.
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - LANES);
  localparam logic [IDXW-1:0] STEP     = IDXW'(LANES);

  vector_reduce_unit_checker #(.BITS(BITS), .N(N), .LANES(LANES)) u_checker ();

  reduce_state_t   state_r;
  reduce_op_t      op_r;
  logic [BITS-1:0] snap_r [N];
  logic [BITS-1:0] acc_r;
  logic [IDXW-1:0] idx_r;
  logic [BITS-1:0] result_r;
  logic            busy_r;
  logic            done_r;
  logic [BITS-1:0] lane_s [LANES];
  logic [BITS-1:0] comb_s;

  // Pick the group of snapshot elements consumed in the current ACCUM cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_s[i] = snap_r[idx_r + IDXW'(i)];
    end
  end

  reduce_lane_tree #(.BITS(BITS), .LANES(LANES)) u_tree (
    .op       (op_r),
    .acc      (acc_r),
    .elems    (lane_s),
    .combined (comb_s)
  );

  // Control FSM with snapshot, accumulator, index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= RED_SUM;
      acc_r    <= '0;
      idx_r    <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        snap_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            snap_r  <= V;
            op_r    <= reduce_op_t'(op);
            acc_r   <= BITS'(reduce_identity(reduce_op_t'(op), BITS));
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ACCUM;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ACCUM: begin
          acc_r <= comb_s;
          idx_r <= idx_r + STEP;
          if (idx_r == LAST_IDX) begin
            result_r <= comb_s;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Directed bench for vector_reduce_unit with BITS=8, N=8, LANES=2 (K=4).
module tb_vector_reduce_unit;

  localparam int BITS  = 8;
  localparam int N     = 8;
  localparam int LANES = 2;
  localparam int K     = N / LANES;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [BITS-1:0] V [N];
  logic            busy;
  logic            done;
  logic [BITS-1:0] result;

  int total;
  int bad;
  int done_cnt;
  int snap_cnt;
  logic [BITS-1:0] vec [N];

  vector_reduce_unit #(.BITS(BITS), .N(N), .LANES(LANES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .V      (V),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one reduction and check its timing, pulse width and result.
  task automatic do_reduce(input logic [BITS-1:0] v_in [N], input logic [1:0] o,
                           input logic [BITS-1:0] exp, input string tag);
    int cycles;
    V = v_in;
    op = o;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " done_low_early"}, 32'(done), 32'd0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(K));
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
    check({tag, " result_held"}, 32'(result), 32'(exp));
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    for (int i = 0; i < N; i++) V[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Sum
    vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_reduce(vec, 2'b00, 8'h24, "sum");

    // 2. Sum wrap
    vec = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_reduce(vec, 2'b00, 8'hF8, "sum_wrap");

    // 3. Signed max / min
    vec = '{8'h80, 8'h7F, 8'h05, 8'hFE, 8'h00, 8'h81, 8'h10, 8'h7E};
    do_reduce(vec, 2'b01, 8'h7F, "smax");
    do_reduce(vec, 2'b10, 8'h80, "smin");
    vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    do_reduce(vec, 2'b01, 8'h80, "smax_neg");

    // 4. XOR
    vec = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    do_reduce(vec, 2'b11, 8'hFF, "xor");
    vec[0] = 8'h81;
    do_reduce(vec, 2'b11, 8'h7F, "xor2");

    // 5. Snapshot isolation and start ignored while busy
    snap_cnt = done_cnt;
    V = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    op = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;                 // edge 0: capture
    start = 1'b0;
    for (int i = 0; i < N; i++) V[i] = 8'h00;
    op = 2'b11;
    @(posedge clk); #1;                 // edge 1
    start = 1'b1;
    @(posedge clk); #1;                 // edge 2: ignored
    start = 1'b0;
    @(posedge clk); #1;                 // edge 3
    start = 1'b1;
    @(posedge clk); #1;                 // edge 4: ignored, final group
    check("snap done", 32'(done), 32'd1);
    check("snap result", 32'(result), 32'h24);
    // start still high across the DONE edge: must be ignored there
    @(posedge clk); #1;                 // edge 5: DONE -> IDLE
    check("done_state ignores start", 32'(busy), 32'd0);
    check("snap single done", 32'(done_cnt - snap_cnt), 32'd1);
    start = 1'b0;
    vec = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    do_reduce(vec, 2'b00, 8'h10, "restart");

    // 6. Reset mid-operation
    V = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    op = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;                 // in ACCUM
    snap_cnt = done_cnt;
    rst_n = 1'b0;
    #2;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst no done", 32'(done_cnt - snap_cnt), 32'd0);
    check("midrst idle", 32'(busy), 32'd0);
    vec = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    do_reduce(vec, 2'b00, 8'h08, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
